wb_decoder_n: RTL and testbench

Parametrised single-master Wishbone address decoder and response handler that connects the CPU-side bus port to N slave peripherals, such as RAM, ROM, flash, UART and digit display. It is the successor to the fixed eight-slave decoder:

- slave count and address-map position are parameters;
- transfers are handled one at a time by a registered state machine;
- a slave that never acknowledges is ended by a timeout and answered with a bus-error response;
- error statistics are kept for debug.

---
 rtl/wb_decoder_n_if.sv | 35 +++
 rtl/wb_decoder_n.sv | 165 ++++++++++++++++
 tb/tb_wb_decoder_n.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wb_decoder_n_if.sv
`default_nettype none
// wb_decoder_n_if: CPU-side and peripheral-side bus signals of the Wishbone decoder.
// The slave modport is the decoder's view; master is the surrounding system's view.
interface wb_decoder_n_if #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int N_SLAVES = 8
);
  logic [AW-1:0]          m_addr_i;
  logic [DW-1:0]          m_data_i;
  logic                   m_we_i;
  logic [DW/8-1:0]        m_sel_i;
  logic                   m_stb_i;
  logic [DW-1:0]          m_data_o;
  logic                   m_ack_o;
  logic                   m_err_o;
  logic [AW-1:0]          s_addr_o;
  logic [DW-1:0]          s_data_o;
  logic                   s_we_o;
  logic [DW/8-1:0]        s_sel_o;
  logic [N_SLAVES-1:0]    s_stb_o;
  logic [N_SLAVES*DW-1:0] s_data_i;
  logic [N_SLAVES-1:0]    s_ack_i;

  modport slave (
    input  m_addr_i, m_data_i, m_we_i, m_sel_i, m_stb_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o
  );

  modport master (
    output m_addr_i, m_data_i, m_we_i, m_sel_i, m_stb_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_decoder_n.sv
`default_nettype none
// wb_decoder_n: single-master Wishbone decoder to N slaves, one transfer at a time,
// with ack timeout, bus-error responses and saturating error statistics.
module wb_decoder_n #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            N_SLAVES = 8,
  parameter int            SEL_HI   = 31,
  parameter int            SEL_LO   = 28,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = '0
) (
  input  logic            clk,
  input  logic            rst,
  wb_decoder_n_if.slave   bus,
  output logic [AW-1:0]   err_addr_o,
  output logic [15:0]     err_cnt_o
);
  localparam int SW = SEL_HI - SEL_LO + 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [N_SLAVES-1:0] STB_ONE = N_SLAVES'(1);
  localparam logic [CW-1:0]       CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, ERR = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [DW/8-1:0]       sel_q, sel_d;
  logic [N_SLAVES-1:0]   stb_q, stb_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [AW-1:0]         err_addr_q, err_addr_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic [SW-1:0]         req_slot;
  logic                  req_hit;
  logic                  ack_sel;
  logic [DW-1:0]         rdata_sel;
  logic [15:0]           err_cnt_inc;

  assign req_slot    = bus.m_addr_i[SEL_HI:SEL_LO];
  assign req_hit     = int'(req_slot) < N_SLAVES;
  assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  // Only the latched slot's ack and data are visible; other slaves are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (int'(slot_q) == k) begin
        ack_sel   = bus.s_ack_i[k];
        rdata_sel = bus.s_data_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.m_stb_i) begin
          addr_d  = bus.m_addr_i;
          wdata_d = bus.m_data_i;
          we_d    = bus.m_we_i;
          sel_d   = bus.m_sel_i;
          slot_d  = req_slot;
          cnt_d   = '0;
          if (req_hit) begin
            state_d = BUSY;
            stb_d   = STB_ONE << req_slot;
          end else begin
            state_d    = ERR;
            err_d      = 1'b1;
            rdata_d    = ERR_DATA;
            err_addr_d = bus.m_addr_i;
            err_cnt_d  = err_cnt_inc;
          end
        end
      end
      BUSY: begin
        // Ack is checked first so it beats a timeout landing in the same cycle.
        if (ack_sel) begin
          state_d = RESP;
          stb_d   = '0;
          ack_d   = 1'b1;
          rdata_d = rdata_sel;
        end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
          state_d    = ERR;
          stb_d      = '0;
          err_d      = 1'b1;
          rdata_d    = ERR_DATA;
          err_addr_d = addr_q;
          err_cnt_d  = err_cnt_inc;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      stb_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      stb_q      <= stb_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.m_data_o = rdata_q;
  assign bus.m_ack_o  = ack_q;
  assign bus.m_err_o  = err_q;
  assign bus.s_addr_o = addr_q;
  assign bus.s_data_o = wdata_q;
  assign bus.s_we_o   = we_q;
  assign bus.s_sel_o  = sel_q;
  assign bus.s_stb_o  = stb_q;
  assign err_addr_o   = err_addr_q;
  assign err_cnt_o    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_decoder_n.sv
`default_nettype none
// Bench for wb_decoder_n: directed cases followed by random transfers, each
// checked against a transaction-level expectation of strobe, latency and response.
module tb_wb_decoder_n;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 6;
  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] err_addr;
  logic [15:0] err_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;
  int resp_cyc     = 0;
  int first_resp;

  logic [31:0] sdata [NS];
  logic [31:0] mdl_err_addr;
  int          mdl_err_cnt;
  logic [3:0]  rnd_slot;

  wb_decoder_n_if #(.AW(AW), .DW(DW), .N_SLAVES(NS)) bus ();

  wb_decoder_n #(
    .AW(AW), .DW(DW), .N_SLAVES(NS), .SEL_HI(31), .SEL_LO(28),
    .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_addr_o (err_addr),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // One transfer. w = wait cycles before the ack, silent = slave never acks,
  // keep = leave m_stb_i high after the response, extra = idle cycles before acceptance.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                      input logic [3:0] sel, input int w, input bit silent,
                      input bit keep, input int extra);
    int          slot, nstb, lat;
    bit          hit, to_err;
    logic [NS-1:0] exp_stb, ack;
    logic [31:0] exp_data;
    slot   = int'(addr[31:28]);
    hit    = slot < NS;
    to_err = !hit || silent || (w > TO);
    nstb   = !hit ? 0 : (to_err ? TO + 1 : w + 1);
    lat    = (hit ? nstb + 1 : 1) + extra;
    for (int k = 0; k < NS; k++) begin
      sdata[k] = $urandom;
      bus.s_data_i[k*DW +: DW] = sdata[k];
    end
    if (to_err) exp_data = ERRD;
    else        exp_data = sdata[slot];
    bus.m_addr_i = addr;
    bus.m_data_i = wd;
    bus.m_we_i   = we;
    bus.m_sel_i  = sel;
    bus.m_stb_i  = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c < lat) begin
        exp_stb = (hit && c > extra) ? (NS'(1) << slot) : '0;
        check("busy_outputs", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o}, {2'b00, exp_stb});
        if (hit && c == extra + 1) begin
          check("s_addr", bus.s_addr_o, addr);
          check("s_data", bus.s_data_o, wd);
          check("s_we_sel", {bus.s_we_o, bus.s_sel_o}, {we, sel});
        end
        ack = NS'($urandom);
        if (hit) ack[slot] = !to_err && (c == lat - 1);
        bus.s_ack_i = ack;
      end else begin
        check("resp_kind", {bus.m_ack_o, bus.m_err_o}, {!to_err, to_err});
        check("resp_data", bus.m_data_o, exp_data);
        check("resp_stb", bus.s_stb_o, '0);
        resp_cyc    = cycle;
        bus.s_ack_i = '0;
        if (!keep) bus.m_stb_i = 1'b0;
      end
    end
    if (to_err) begin
      if (mdl_err_cnt < 65535) mdl_err_cnt++;
      mdl_err_addr = addr;
    end
    if (!keep) begin
      @(posedge clk); #1;
      check("pulse_off", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o}, '0);
      check("m_data_hold", bus.m_data_o, exp_data);
      check("s_addr_hold", bus.s_addr_o, addr);
      check("err_addr", err_addr, mdl_err_addr);
      check("err_cnt", err_cnt, 64'(mdl_err_cnt));
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.m_addr_i = '0;
    bus.m_data_i = '0;
    bus.m_we_i   = 1'b0;
    bus.m_sel_i  = '0;
    bus.m_stb_i  = 1'b0;
    bus.s_data_i = '0;
    bus.s_ack_i  = '0;
    mdl_err_addr = '0;
    mdl_err_cnt  = 0;
    #2 rst = 1'b0;
    #10;
    check("rst_ctrl", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o}, '0);
    check("rst_m_data", bus.m_data_o, '0);
    check("rst_s_addr", bus.s_addr_o, '0);
    check("rst_s_data", bus.s_data_o, '0);
    check("rst_err_addr", err_addr, '0);
    check("rst_err_cnt", err_cnt, '0);
    @(posedge clk); #1 rst = 1'b1;

    xfer(32'h0000_0010, $urandom, 1'b0, 4'hF, 0, 1'b0, 1'b0, 0);
    xfer(32'h4000_0004, 32'h1234_5678, 1'b1, 4'b0011, 3, 1'b0, 1'b0, 0);
    xfer(32'h7000_0000, $urandom, 1'b0, 4'hF, 0, 1'b0, 1'b0, 0);
    xfer(32'h2000_0000, $urandom, 1'b0, 4'hF, 0, 1'b1, 1'b0, 0);
    xfer(32'h2000_0008, $urandom, 1'b0, 4'hF, 4, 1'b0, 1'b0, 0);

    // Reset in the middle of a busy transfer.
    bus.m_addr_i = 32'h2000_0000;
    bus.m_we_i   = 1'b0;
    bus.m_stb_i  = 1'b1;
    bus.s_ack_i  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_stb", bus.s_stb_o, 6'h04);
    #2 rst = 1'b0;
    #1;
    check("abort_stb", bus.s_stb_o, '0);
    check("abort_s_addr", bus.s_addr_o, '0);
    check("abort_err_cnt", err_cnt, '0);
    mdl_err_cnt  = 0;
    mdl_err_addr = '0;
    bus.m_stb_i  = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o}, '0);
    end

    // Back-to-back reads with m_stb_i held high throughout.
    xfer(32'h1000_0000, $urandom, 1'b0, 4'hF, 0, 1'b0, 1'b1, 0);
    first_resp = resp_cyc;
    xfer(32'h3000_0000, $urandom, 1'b0, 4'hF, 0, 1'b0, 1'b0, 1);
    check("b2b_spacing", 64'(resp_cyc - first_resp), 64'd3);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_slot = 4'($urandom_range(NS, 15));
      else                           rnd_slot = 4'($urandom_range(0, NS - 1));
      xfer({rnd_slot, 28'($urandom)}, $urandom, 1'($urandom), 4'($urandom),
           $urandom_range(0, 6), ($urandom_range(0, 7) == 0), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
`default_nettype wire
